// File: rtl/i2c_slave_regbank.sv
// Pointer-addressed, auto-incrementing 8-bit register bank behind an i2c_slave byte interface, plus a direct host port.
// Latency: I2C-side events act 3 clk after the input edge (2-flop sync + edge flop); host writes land at the next posedge.
// Backpressure: none; the i2c_slave must sample slv_tx_data no earlier than 4 clk after raising slv_data_req.
module i2c_slave_regbank #(
  parameter int                   REG_COUNT = 16,
  parameter int                   PTR_W     = 4,
  parameter logic [REG_COUNT-1:0] RO_MASK   = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slv_busy,
  input  logic             slv_new_data,
  input  logic             slv_data_req,
  input  logic [7:0]       slv_rx_data,
  output logic [7:0]       slv_tx_data,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rd_data,
  input  logic             host_we,
  input  logic [7:0]       host_wr_data,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [PTR_W-1:0] ptr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PTR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // [0],[1] synchroniser stages, [2] edge-detect history
  logic [2:0]       r_busy_sync;
  logic [2:0]       r_nd_sync;
  logic [2:0]       r_dr_sync;

  // After reset, busy must be seen low once before a rise counts, so a busy
  // already high at reset release does not open a transaction.
  logic [1:0]       r_settle;
  logic             r_armed;

  logic [7:0]       r_regs [REG_COUNT];
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_tx;
  logic             r_wr_strobe;
  logic [PTR_W-1:0] r_wr_addr;

  logic             w_busy_rise;
  logic             w_busy_fall;
  logic             w_nd_rise;
  logic             w_dr_rise;
  logic             w_ptr_load;
  logic             w_data_wr;
  logic             w_rd;
  logic             w_i2c_we;

  assign w_busy_rise = r_armed & r_busy_sync[1] & ~r_busy_sync[2];
  assign w_busy_fall = ~r_busy_sync[1] & r_busy_sync[2];
  assign w_nd_rise   = r_nd_sync[1] & ~r_nd_sync[2];
  assign w_dr_rise   = r_dr_sync[1] & ~r_dr_sync[2];

  // Synchronise the slave strobes and track when busy is trustworthy after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_sync <= 3'b000;
      r_nd_sync   <= 3'b000;
      r_dr_sync   <= 3'b000;
      r_settle    <= 2'd0;
      r_armed     <= 1'b0;
    end else begin
      r_busy_sync <= {r_busy_sync[1:0], slv_busy};
      r_nd_sync   <= {r_nd_sync[1:0], slv_new_data};
      r_dr_sync   <= {r_dr_sync[1:0], slv_data_req};
      if (r_settle != 2'd3) begin
        r_settle <= r_settle + 2'd1;
      end
      if ((r_settle == 2'd3) && !r_busy_sync[1]) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Transaction state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-event actions; a write event shadows a same-clk read event
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_load  = 1'b0;
    w_data_wr   = 1'b0;
    w_rd        = 1'b0;
    if (w_busy_fall) begin
      w_state_nxt = ST_IDLE;
    end else if (w_busy_rise) begin
      w_state_nxt = ST_PTR;
    end else begin
      case (r_state)
        ST_PTR: begin
          if (w_nd_rise) begin
            w_ptr_load  = 1'b1;
            w_state_nxt = ST_DATA;
          end else if (w_dr_rise) begin
            w_rd        = 1'b1;
            w_state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_nd_rise) begin
            w_data_wr = 1'b1;
          end else if (w_dr_rise) begin
            w_rd = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_i2c_we = w_data_wr & ~RO_MASK[r_ptr];

  // Pointer, read data and write strobe; the pointer advances even on a dropped read-only write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_tx        <= 8'h00;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      r_wr_strobe <= w_i2c_we;
      if (w_i2c_we) begin
        r_wr_addr <= r_ptr;
      end
      if (w_ptr_load) begin
        r_ptr <= slv_rx_data[PTR_W-1:0];
      end else if (w_data_wr || w_rd) begin
        r_ptr <= r_ptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_tx <= r_regs[r_ptr];
      end
    end
  end

  // Register file; an I2C write beats a host write to the same index in the same clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (w_i2c_we && (r_ptr == PTR_W'(i))) begin
          r_regs[i] <= slv_rx_data;
        end else if (host_we && (host_addr == PTR_W'(i))) begin
          r_regs[i] <= host_wr_data;
        end
      end
    end
  end

  assign slv_tx_data  = r_tx;
  assign host_rd_data = r_regs[host_addr];
  assign wr_strobe    = r_wr_strobe;
  assign wr_addr      = r_wr_addr;
  assign ptr          = r_ptr;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Directed bench for i2c_slave_regbank: stimulus pushes expected write strobes and read bytes
// into queues; independent monitors pop and compare when the DUT strobes or a read is served.
module tb_i2c_slave_regbank;

  localparam int REG_COUNT = 16;
  localparam int PTR_W     = 4;

  logic             clk;
  logic             rst;
  logic             slv_busy;
  logic             slv_new_data;
  logic             slv_data_req;
  logic [7:0]       slv_rx_data;
  logic [7:0]       slv_tx_data;
  logic [PTR_W-1:0] host_addr;
  logic [7:0]       host_rd_data;
  logic             host_we;
  logic [7:0]       host_wr_data;
  logic             wr_strobe;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] ptr;

  int total;
  int bad;
  int wr_q[$];
  int rd_q[$];
  int wr_exp;
  int rd_exp;

  i2c_slave_regbank #(
    .REG_COUNT (REG_COUNT),
    .PTR_W     (PTR_W),
    .RO_MASK   (16'h0004)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .slv_busy     (slv_busy),
    .slv_new_data (slv_new_data),
    .slv_data_req (slv_data_req),
    .slv_rx_data  (slv_rx_data),
    .slv_tx_data  (slv_tx_data),
    .host_addr    (host_addr),
    .host_rd_data (host_rd_data),
    .host_we      (host_we),
    .host_wr_data (host_wr_data),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .ptr          (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n posedges, then step off the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busy_set(input logic v);
    slv_busy = v;
    tick(6);
  endtask

  // One received byte; exp_addr >= 0 means a write strobe to that index is expected
  task automatic send_byte(input logic [7:0] b, input int exp_addr);
    if (exp_addr >= 0) wr_q.push_back(exp_addr);
    slv_rx_data  = b;
    slv_new_data = 1'b1;
    tick(6);
    slv_new_data = 1'b0;
    tick(6);
  endtask

  task automatic read_byte(input logic [7:0] exp_b);
    rd_q.push_back(int'(exp_b));
    slv_data_req = 1'b1;
    tick(6);
    slv_data_req = 1'b0;
    tick(6);
  endtask

  task automatic host_write(input logic [PTR_W-1:0] a, input logic [7:0] d);
    host_addr    = a;
    host_wr_data = d;
    host_we      = 1'b1;
    tick(1);
    host_we      = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [PTR_W-1:0] a, input logic [7:0] exp_b);
    host_addr = a;
    #1;
    check(name, int'(host_rd_data), int'(exp_b));
  endtask

  // Write-strobe monitor: every strobe must match the next expected index
  always @(negedge clk) begin
    if (!rst && wr_strobe) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_strobe_unexpected: got strobe at addr 0x%0h, expected none", wr_addr);
      end else begin
        wr_exp = wr_q.pop_front();
        check("wr_addr", int'(wr_addr), wr_exp);
      end
    end
  end

  // Read monitor: a data_req rise must have produced the expected byte 5 clk later
  always begin
    @(posedge slv_data_req);
    repeat (5) @(negedge clk);
    if (rd_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL rd_unexpected: got 0x%0h, expected no read", slv_tx_data);
    end else begin
      rd_exp = rd_q.pop_front();
      check("slv_tx_data", int'(slv_tx_data), rd_exp);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    slv_busy = 1'b0;
    slv_new_data = 1'b0;
    slv_data_req = 1'b0;
    slv_rx_data = 8'h00;
    host_addr = '0;
    host_we = 1'b0;
    host_wr_data = 8'h00;
    tick(3);

    // Reset state
    check("rst_ptr", int'(ptr), 0);
    check("rst_tx", int'(slv_tx_data), 0);
    check("rst_strobe", int'(wr_strobe), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    chk_reg("rst_reg0", 4'd0, 8'h00);
    rst = 1'b0;
    tick(10);

    // Pointer then two writes
    busy_set(1'b1);
    send_byte(8'h03, -1);
    send_byte(8'hAA, 3);
    send_byte(8'h55, 4);
    busy_set(1'b0);
    chk_reg("t1_reg3", 4'd3, 8'hAA);
    chk_reg("t1_reg4", 4'd4, 8'h55);
    check("t1_ptr", int'(ptr), 5);

    // Wrap from 15 to 0
    busy_set(1'b1);
    send_byte(8'h0F, -1);
    send_byte(8'h11, 15);
    send_byte(8'h22, 0);
    busy_set(1'b0);
    chk_reg("t2_reg15", 4'd15, 8'h11);
    chk_reg("t2_reg0", 4'd0, 8'h22);
    check("t2_ptr", int'(ptr), 1);

    // Host preload, set pointer, restart, read two bytes
    host_write(4'd6, 8'h5A);
    host_write(4'd7, 8'hC3);
    chk_reg("t3_reg6", 4'd6, 8'h5A);
    busy_set(1'b1);
    send_byte(8'h06, -1);
    busy_set(1'b0);
    busy_set(1'b1);
    read_byte(8'h5A);
    read_byte(8'hC3);
    busy_set(1'b0);
    check("t3_ptr", int'(ptr), 8);

    // Read-only register 2 drops I2C writes but accepts host writes
    host_write(4'd2, 8'h3C);
    busy_set(1'b1);
    send_byte(8'h02, -1);
    send_byte(8'h77, -1);
    chk_reg("t4_reg2", 4'd2, 8'h3C);
    check("t4_ptr", int'(ptr), 3);
    send_byte(8'h88, 3);
    busy_set(1'b0);
    chk_reg("t4_reg3", 4'd3, 8'h88);

    // Same-clk host and I2C write to reg 9: I2C wins
    busy_set(1'b1);
    send_byte(8'h09, -1);
    wr_q.push_back(9);
    host_addr    = 4'd9;
    host_wr_data = 8'h01;
    slv_rx_data  = 8'h02;
    slv_new_data = 1'b1;
    tick(2);
    host_we = 1'b1;
    tick(1);
    host_we = 1'b0;
    tick(3);
    slv_new_data = 1'b0;
    tick(6);
    busy_set(1'b0);
    chk_reg("t5_reg9_collide", 4'd9, 8'h02);
    host_write(4'd9, 8'h01);
    chk_reg("t5_reg9_host", 4'd9, 8'h01);

    // Reset mid-transaction, busy held high across release
    busy_set(1'b1);
    send_byte(8'h05, -1);
    rst = 1'b1;
    tick(2);
    check("t6_ptr_rst", int'(ptr), 0);
    chk_reg("t6_reg3_rst", 4'd3, 8'h00);
    chk_reg("t6_reg9_rst", 4'd9, 8'h00);
    rst = 1'b0;
    tick(10);
    send_byte(8'h44, -1);
    chk_reg("t6_reg5", 4'd5, 8'h00);
    chk_reg("t6_reg4", 4'd4, 8'h00);
    check("t6_ptr", int'(ptr), 0);
    busy_set(1'b0);
    tick(10);

    while (wr_q.size() > 0) begin
      wr_exp = wr_q.pop_front();
      total++;
      bad++;
      $display("FAIL wr_strobe_missing: got none, expected strobe at addr 0x%0h", wr_exp);
    end
    while (rd_q.size() > 0) begin
      rd_exp = rd_q.pop_front();
      total++;
      bad++;
      $display("FAIL rd_missing: got none, expected 0x%0h", rd_exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
